// File: rtl/aes_bram_port_ctrl.sv
// aes_bram_port_ctrl: single-port BRAM controller shared by the AES
// engine and a host requester, round-robin arbitrated.
module aes_bram_port_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                  aes_clk,
  input  logic                  aes_rst,
  input  logic                  aes_start_read,
  input  logic                  aes_start_write,
  input  logic [ADDR_WIDTH-1:0] aes_bram_addr,
  input  logic [31:0]           aes_bram_write_data,
  output logic [31:0]           aes_bram_read_data,
  output logic                  bram_complete,
  input  logic                  host_start_read,
  input  logic                  host_start_write,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [31:0]           host_wdata,
  output logic [31:0]           host_rdata,
  output logic                  host_complete,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [31:0]           bram_wdata,
  input  logic [31:0]           bram_rdata,
  output logic [1:0]            err_flags,
  input  logic                  err_clr
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RD_WAIT,
    DONE
  } state_t;

  localparam logic AES  = 1'b0;
  localparam logic HOST = 1'b1;

  state_t state_q;
  state_t state_d;

  logic                  armed_aes;
  logic                  armed_host;
  logic                  last_grant;
  logic                  gnt;
  logic                  op_wr;
  logic                  mis_q;
  logic [31:0]           wdata_q;
  logic [2:0]            cnt_q;

  logic                  aes_pend;
  logic                  host_pend;
  logic                  grant_valid;
  logic                  grant_sel;
  logic                  cnt_zero;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]           sel_wdata;
  logic                  sel_rd;
  logic                  sel_wr;

  assign aes_pend  = (aes_start_read | aes_start_write) & armed_aes;
  assign host_pend = (host_start_read | host_start_write) & armed_host;

  assign grant_valid = (state_q == IDLE) && (aes_pend || host_pend);
  // On a tie the requester not served last wins; otherwise whoever is pending.
  assign grant_sel = (aes_pend && host_pend) ? ~last_grant : host_pend;

  assign sel_addr  = grant_sel ? host_addr : aes_bram_addr;
  assign sel_wdata = grant_sel ? host_wdata : aes_bram_write_data;
  assign sel_rd    = grant_sel ? host_start_read : aes_start_read;
  assign sel_wr    = grant_sel ? host_start_write : aes_start_write;

  assign cnt_zero = (cnt_q == 3'd0);

  // State register.
  always_ff @(posedge aes_clk) begin
    if (aes_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and the combinational BRAM strobes / completion pulses.
  always_comb begin
    state_d       = state_q;
    bram_en       = 1'b0;
    bram_we       = 4'h0;
    bram_wdata    = 32'h0;
    bram_complete = 1'b0;
    host_complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) state_d = ISSUE;
      end
      ISSUE: begin
        bram_en = 1'b1;
        if (op_wr) begin
          bram_we    = 4'hF;
          bram_wdata = wdata_q;
          state_d    = DONE;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_zero) state_d = DONE;
      end
      DONE: begin
        bram_complete = (gnt == AES);
        host_complete = (gnt == HOST);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant latch, latency counter, read capture, re-arm flags and errors.
  always_ff @(posedge aes_clk) begin
    if (aes_rst) begin
      armed_aes          <= 1'b1;
      armed_host         <= 1'b1;
      last_grant         <= HOST;
      gnt                <= AES;
      op_wr              <= 1'b0;
      mis_q              <= 1'b0;
      wdata_q            <= 32'h0;
      cnt_q              <= 3'd0;
      bram_addr          <= '0;
      aes_bram_read_data <= 32'h0;
      host_rdata         <= 32'h0;
      err_flags          <= 2'b00;
    end else begin
      if (grant_valid) begin
        gnt        <= grant_sel;
        last_grant <= grant_sel;
        op_wr      <= sel_wr;
        mis_q      <= |sel_addr[1:0];
        wdata_q    <= sel_wdata;
        bram_addr  <= {sel_addr[ADDR_WIDTH-1:2], 2'b00};
      end

      if (state_q == ISSUE && !op_wr)
        cnt_q <= 3'(READ_LATENCY - 1);
      else if (state_q == RD_WAIT && !cnt_zero)
        cnt_q <= cnt_q - 3'd1;

      if (state_q == RD_WAIT && cnt_zero) begin
        if (gnt == HOST) host_rdata <= bram_rdata;
        else             aes_bram_read_data <= bram_rdata;
      end

      if (state_q == DONE && gnt == AES)
        armed_aes <= 1'b0;
      else if (!aes_start_read && !aes_start_write)
        armed_aes <= 1'b1;

      if (state_q == DONE && gnt == HOST)
        armed_host <= 1'b0;
      else if (!host_start_read && !host_start_write)
        armed_host <= 1'b1;

      if (err_clr) begin
        err_flags <= 2'b00;
      end else begin
        if (grant_valid && sel_rd && sel_wr)
          err_flags[1] <= 1'b1;
        if (state_q == ISSUE && mis_q)
          err_flags[0] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_bram_port_ctrl.sv
// tb_aes_bram_port_ctrl: directed and random transactions against a
// transaction-level memory model with exact completion timing.
module tb_aes_bram_port_ctrl;

  localparam int AW = 32;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          aes_rst;
  logic          aes_start_read;
  logic          aes_start_write;
  logic [AW-1:0] aes_bram_addr;
  logic [31:0]   aes_bram_write_data;
  logic [31:0]   aes_bram_read_data;
  logic          bram_complete;
  logic          host_start_read;
  logic          host_start_write;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata;
  logic [31:0]   host_rdata;
  logic          host_complete;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_wdata;
  logic [31:0]   bram_rdata;
  logic [1:0]    err_flags;
  logic          err_clr;

  logic          init_req;
  logic [31:0]   mem [256];
  logic [31:0]   pipe [RL];
  int            en_count = 0;

  logic [31:0]   ref_mem [256];
  logic [31:0]   exp_rd [2];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  aes_bram_port_ctrl #(
    .ADDR_WIDTH(AW),
    .READ_LATENCY(RL)
  ) dut (
    .aes_clk(clk),
    .aes_rst(aes_rst),
    .aes_start_read(aes_start_read),
    .aes_start_write(aes_start_write),
    .aes_bram_addr(aes_bram_addr),
    .aes_bram_write_data(aes_bram_write_data),
    .aes_bram_read_data(aes_bram_read_data),
    .bram_complete(bram_complete),
    .host_start_read(host_start_read),
    .host_start_write(host_start_write),
    .host_addr(host_addr),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .host_complete(host_complete),
    .bram_en(bram_en),
    .bram_we(bram_we),
    .bram_addr(bram_addr),
    .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata),
    .err_flags(err_flags),
    .err_clr(err_clr)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  // BRAM with RL-cycle read latency; poison value when not reading.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (bram_en && bram_we == 4'hF) begin
      mem[bram_addr[9:2]] <= bram_wdata;
    end
    pipe[0] <= (bram_en && bram_we == 4'h0) ? mem[bram_addr[9:2]] : 32'hBAD0_BAD0;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    if (bram_en) en_count <= en_count + 1;
  end
  assign bram_rdata = pipe[RL-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit h, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (h) begin
      host_start_read = rd; host_start_write = wr;
      host_addr = a; host_wdata = d;
    end else begin
      aes_start_read = rd; aes_start_write = wr;
      aes_bram_addr = a; aes_bram_write_data = d;
    end
  endtask

  // Called at a negedge with the requester idle and armed.
  task automatic xfer(input bit h, input bit rd, input bit wr,
                      input logic [31:0] a, input logic [31:0] d);
    int lat;
    logic cmp;
    logic oth;
    lat = wr ? 2 : RL + 2;
    drive(h, rd, wr, a, d);
    @(negedge clk);
    chk("issue_en", bram_en, 1'b1);
    chk("issue_addr", bram_addr, {a[31:2], 2'b00});
    chk("issue_we", bram_we, wr ? 4'hF : 4'h0);
    chk("issue_wdata", bram_wdata, wr ? d : 32'h0);
    for (int c = 2; c <= lat; c++) begin
      @(negedge clk);
      cmp = h ? host_complete : bram_complete;
      oth = h ? bram_complete : host_complete;
      chk("complete", cmp, c == lat);
      chk("other_complete", oth, 1'b0);
      chk("en_low", bram_en, 1'b0);
    end
    if (wr) ref_mem[a[9:2]] = d;
    else    exp_rd[h] = ref_mem[a[9:2]];
    chk("aes_rdata", aes_bram_read_data, exp_rd[0]);
    chk("host_rdata", host_rdata, exp_rd[1]);
    drive(h, 1'b0, 1'b0, a, d);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit found;
    bit h;
    bit wr;
    logic [31:0] a;
    logic [31:0] d;
    int base;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    aes_rst = 1'b1;
    init_req = 1'b1;
    err_clr = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_en", bram_en, 1'b0);
    chk("rst_we", bram_we, 4'h0);
    chk("rst_addr", bram_addr, 32'h0);
    chk("rst_wdata", bram_wdata, 32'h0);
    chk("rst_cmp", bram_complete, 1'b0);
    chk("rst_hcmp", host_complete, 1'b0);
    chk("rst_ard", aes_bram_read_data, 32'h0);
    chk("rst_hrd", host_rdata, 32'h0);
    chk("rst_err", err_flags, 2'b00);
    init_req = 1'b0;
    aes_rst = 1'b0;
    @(negedge clk);

    // Engine write then read back at 0x40, write 0x50, host read 0x50.
    xfer(1'b0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
    xfer(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    chk("rd_40", aes_bram_read_data, 32'hDEAD_BEEF);
    xfer(1'b0, 1'b0, 1'b1, 32'h50, 32'h0123_4567);
    xfer(1'b1, 1'b1, 1'b0, 32'h50, 32'h0);
    chk("rd_50", host_rdata, 32'h0123_4567);

    // Tie after a host grant: engine first, host right after engine DONE.
    drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h44, 32'h0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk("tie_aes_cmp", bram_complete, c == 4);
      chk("tie_host_cmp", host_complete, c == 9);
      if (c == 4) begin
        exp_rd[0] = ref_mem[8'h10];
        chk("tie_aes_rd", aes_bram_read_data, exp_rd[0]);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      if (c == 6) begin
        chk("tie_host_en", bram_en, 1'b1);
        chk("tie_host_addr", bram_addr, 32'h44);
      end
    end
    exp_rd[1] = ref_mem[8'h11];
    chk("tie_host_rd", host_rdata, exp_rd[1]);
    chk("tie_aes_kept", aes_bram_read_data, exp_rd[0]);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);

    // Re-arm: a held request is serviced once only.
    base = en_count;
    drive(1'b0, 1'b1, 1'b0, 32'h50, 32'h0);
    repeat (RL + 2) @(negedge clk);
    chk("rearm_cmp", bram_complete, 1'b1);
    exp_rd[0] = ref_mem[8'h14];
    repeat (20) @(negedge clk);
    chk("rearm_once", en_count - base, 1);
    drive(1'b0, 1'b0, 1'b0, 32'h50, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h50, 32'h0);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      found = bram_complete;
    end
    chk("rearm_second", found, 1'b1);
    chk("rearm_twice", en_count - base, 2);
    chk("rearm_rd", aes_bram_read_data, exp_rd[0]);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);

    // Misaligned host read, clear, then read+write together.
    xfer(1'b1, 1'b1, 1'b0, 32'h43, 32'h0);
    chk("err_mis", err_flags, 2'b01);
    err_clr = 1'b1;
    @(negedge clk);
    chk("err_clr", err_flags, 2'b00);
    err_clr = 1'b0;
    xfer(1'b0, 1'b1, 1'b1, 32'h60, 32'hCAFE_F00D);
    chk("err_rw", err_flags, 2'b10);
    xfer(1'b1, 1'b1, 1'b0, 32'h60, 32'h0);
    chk("rw_wrote", host_rdata, 32'hCAFE_F00D);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr2", err_flags, 2'b00);

    // Reset during RD_WAIT abandons the read.
    drive(1'b0, 1'b1, 1'b0, 32'h50, 32'h0);
    @(negedge clk);
    @(negedge clk);
    aes_rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    chk("mrst_cmp", bram_complete, 1'b0);
    chk("mrst_ard", aes_bram_read_data, 32'h0);
    chk("mrst_hrd", host_rdata, 32'h0);
    chk("mrst_addr", bram_addr, 32'h0);
    chk("mrst_en", bram_en, 1'b0);
    aes_rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("mrst_nocmp", bram_complete, 1'b0);
    end
    xfer(1'b0, 1'b1, 1'b0, 32'h50, 32'h0);

    // Random single transactions.
    for (int n = 0; n < 40; n++) begin
      h  = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      d  = $urandom;
      xfer(h, ~wr, wr, a, d);
    end
    chk("rand_err", err_flags, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
